// File: rtl/mips_intc_pkg.sv
// Shared constants for the memory-mapped interrupt controller: the register
// window offsets and the bit positions of the fields inside the read words.
package mips_intc_pkg;

   localparam int NSRC_MAX = 16;

   localparam logic [1:0] INTC_PEND  = 2'd0;
   localparam logic [1:0] INTC_MASK  = 2'd1;
   localparam logic [1:0] INTC_MODE  = 2'd2;
   localparam logic [1:0] INTC_CLAIM = 2'd3;

   localparam int OVR_LSB         = 16;
   localparam int CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/intc_sync.sv
// Three-flop synchronizer for one asynchronous interrupt request. The first two
// flops resolve metastability; the third holds the previous synchronized value
// so that a rising edge can be detected without touching the raw input.
module intc_sync (
   input  logic clk,
   input  logic rst,
   input  logic irq_i,
   output logic rise_o,
   output logic lvl_o
);

   logic s1_q, s2_q, s3_q;

   // Shift the raw request through the chain; reset flushes any request in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= irq_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;
   assign lvl_o  = s2_q;

endmodule

// File: rtl/mips_intc.sv
// Interrupt controller top: synchronizes peripheral requests, latches them as
// pending (edge or level per source), tracks lost edges as overruns, masks them
// onto the registered INT lines and exposes a four-word software window with
// write-one-to-clear, mask, mode and claim/end-of-interrupt registers.
module mips_intc
   import mips_intc_pkg::*;
#(
   parameter int NSRC = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_in,
   input  logic            sel,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [31:0]     wd,
   output logic [31:0]     rd,
   output logic [NSRC-1:0] INT
);

   logic [NSRC-1:0] rise, lvl, setVec, clrVec, ovrClr, eoiVec, active;
   logic [NSRC-1:0] pend_q, pend_d, ovr_q, ovr_d;
   logic [NSRC-1:0] mask_q, mask_d, mode_q, mode_d, int_q, int_d;
   logic [4:0]      claimIdx;
   logic [31:0]     rdWord;
   logic            pendWr, maskWr, modeWr, eoiWr;
   logic            unusedWd;

   for (genvar g = 0; g < NSRC; g++) begin : gSync
      intc_sync uSync (
         .clk    (clk),
         .rst    (rst),
         .irq_i  (irq_in[g]),
         .rise_o (rise[g]),
         .lvl_o  (lvl[g])
      );
   end

   // Not every write-data bit maps to a register field for small NSRC.
   assign unusedWd = ^wd;

   // Decode bus writes and compute the next value of every register; a new
   // request always beats a clear arriving in the same cycle.
   always_comb begin
      pendWr = sel & we & (addr == INTC_PEND);
      maskWr = sel & we & (addr == INTC_MASK);
      modeWr = sel & we & (addr == INTC_MODE);
      eoiWr  = sel & we & (addr == INTC_CLAIM);

      ovrClr = pendWr ? wd[OVR_LSB +: NSRC] : '0;
      eoiVec = '0;
      for (int i = 0; i < NSRC; i++) begin
         eoiVec[i] = eoiWr & (wd[4:0] == 5'(i));
      end
      clrVec = (pendWr ? wd[NSRC-1:0] : '0) | eoiVec;

      setVec = (mode_q & rise) | (~mode_q & lvl);
      pend_d = setVec | (pend_q & ~clrVec);
      ovr_d  = (mode_q & rise & pend_q) | (ovr_q & ~ovrClr);
      mask_d = maskWr ? wd[NSRC-1:0] : mask_q;
      mode_d = modeWr ? wd[NSRC-1:0] : mode_q;
      int_d  = pend_q & mask_q;
   end

   // Hold all controller state; reset drops everything at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
         ovr_q  <= '0;
         mask_q <= '0;
         mode_q <= '0;
         int_q  <= '0;
      end else begin
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         mask_q <= mask_d;
         mode_q <= mode_d;
         int_q  <= int_d;
      end
   end

   // Lowest-numbered enabled pending source wins the claim.
   always_comb begin
      active   = pend_q & mask_q;
      claimIdx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) claimIdx = 5'(i);
      end
   end

   // Assemble the addressed register word; reserved bits stay zero.
   always_comb begin
      rdWord = '0;
      case (addr)
         INTC_PEND: begin
            rdWord[NSRC-1:0]         = pend_q;
            rdWord[OVR_LSB +: NSRC]  = ovr_q;
         end
         INTC_MASK: rdWord[NSRC-1:0] = mask_q;
         INTC_MODE: rdWord[NSRC-1:0] = mode_q;
         default: begin
            rdWord[CLAIM_VALID_BIT] = |active;
            rdWord[4:0]             = claimIdx;
         end
      endcase
   end

   assign rd  = sel ? rdWord : '0;
   assign INT = int_q;

endmodule

// File: tb/tb_mips_intc.sv
// Directed bench for the interrupt controller: walks reset, the edge path
// latency, claim priority, overrun capture, level re-set and mask/EOI bounds.
module tb_mips_intc;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  irq_in;
   logic        sel, we;
   logic [1:0]  addr;
   logic [31:0] wd, rd;
   logic [4:0]  INT;
   logic [31:0] rdVal;
   int          checks = 0;
   int          errors = 0;

   mips_intc #(.NSRC(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in),
      .sel    (sel),
      .we     (we),
      .addr   (addr),
      .wd     (wd),
      .rd     (rd),
      .INT    (INT)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wd = d;
      tick();
      sel = 1'b0; we = 1'b0; wd = '0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      sel = 1'b1; we = 1'b0; addr = a;
      #1;
      d = rd;
      sel = 1'b0;
   endtask

   // One-cycle request pulse followed by two idle edges: pending is set on the third edge.
   task automatic applyStimulus(input logic [4:0] pulse);
      irq_in = pulse;
      tick();
      irq_in = '0;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b0; irq_in = '1; sel = 0; we = 0; addr = 0; wd = 0;
      tick(); tick();
      checkOutput("rst INT", 32'(INT), 32'h0);
      busRead(2'd0, rdVal); checkOutput("rst PEND", rdVal, 32'h0);
      busRead(2'd1, rdVal); checkOutput("rst MASK", rdVal, 32'h0);
      busRead(2'd2, rdVal); checkOutput("rst MODE", rdVal, 32'h0);
      checkOutput("rd sel0", rd, 32'h0);
      rst = 1'b1;
      repeat (4) tick();
      checkOutput("post-rst INT masked", 32'(INT), 32'h0);
      busRead(2'd0, rdVal); checkOutput("post-rst level PEND", rdVal, 32'h1F);
      irq_in = '0;
      tick(); tick();
      busWrite(2'd0, 32'h1F);
      busRead(2'd0, rdVal); checkOutput("post-rst clear", rdVal, 32'h0);

      // Edge path latency and claim/EOI
      busWrite(2'd2, 32'h1F);
      busWrite(2'd1, 32'h1F);
      irq_in = 5'b00100;
      tick();
      irq_in = '0;
      tick(); tick();
      checkOutput("edge INT before edge4", 32'(INT), 32'h0);
      busRead(2'd0, rdVal); checkOutput("edge PEND edge3", rdVal, 32'h4);
      tick();
      checkOutput("edge INT edge4", 32'(INT), 32'h4);
      busRead(2'd3, rdVal); checkOutput("claim src2", rdVal, 32'h8000_0002);
      busWrite(2'd3, 32'd2);
      checkOutput("INT held after EOI", 32'(INT), 32'h4);
      tick();
      checkOutput("INT drop after EOI", 32'(INT), 32'h0);

      // Priority
      applyStimulus(5'b01010);
      busRead(2'd3, rdVal); checkOutput("claim prio 1", rdVal, 32'h8000_0001);
      busWrite(2'd3, 32'd1);
      busRead(2'd3, rdVal); checkOutput("claim prio 3", rdVal, 32'h8000_0003);
      busWrite(2'd3, 32'd3);
      busRead(2'd3, rdVal); checkOutput("claim none", rdVal, 32'h0);

      // Overrun
      applyStimulus(5'b00001);
      applyStimulus(5'b00001);
      busRead(2'd0, rdVal); checkOutput("overrun set", rdVal, 32'h0001_0001);
      checkOutput("overrun INT", 32'(INT), 32'h1);
      busWrite(2'd0, 32'h0001_0000);
      busRead(2'd0, rdVal); checkOutput("overrun W1C", rdVal, 32'h0000_0001);
      busWrite(2'd0, 32'h1);
      busRead(2'd0, rdVal); checkOutput("overrun pend clr", rdVal, 32'h0);

      // Level mode, set beats clear
      busWrite(2'd2, 32'h0);
      irq_in = 5'b10000;
      tick(); tick(); tick();
      busRead(2'd0, rdVal); checkOutput("level pend", rdVal, 32'h10);
      busWrite(2'd0, 32'h10);
      busRead(2'd0, rdVal); checkOutput("level set wins", rdVal, 32'h10);
      irq_in = '0;
      tick(); tick();
      busWrite(2'd0, 32'h10);
      busRead(2'd0, rdVal); checkOutput("level cleared", rdVal, 32'h0);
      checkOutput("level INT lag", 32'(INT), 32'h10);
      tick();
      checkOutput("level INT off", 32'(INT), 32'h0);

      // Mask and EOI bounds
      busWrite(2'd1, 32'h0);
      applyStimulus(5'b00010);
      tick();
      checkOutput("masked INT", 32'(INT), 32'h0);
      busRead(2'd3, rdVal); checkOutput("masked claim", rdVal, 32'h0);
      busRead(2'd0, rdVal); checkOutput("masked pend", rdVal, 32'h2);
      busWrite(2'd1, 32'h2);
      checkOutput("unmask same edge", 32'(INT), 32'h0);
      tick();
      checkOutput("unmask next edge", 32'(INT), 32'h2);
      busWrite(2'd3, 32'd7);
      busRead(2'd0, rdVal); checkOutput("EOI 7 ignored", rdVal, 32'h2);
      checkOutput("EOI 7 INT", 32'(INT), 32'h2);

      // Reset while a request sits in the sync chain
      irq_in = 5'b00001;
      tick();
      #2 rst = 1'b0;
      #1 irq_in = '0;
      checkOutput("async rst INT", 32'(INT), 32'h0);
      tick();
      rst = 1'b1;
      repeat (4) tick();
      busRead(2'd0, rdVal); checkOutput("mid-sync rst PEND", rdVal, 32'h0);
      busRead(2'd1, rdVal); checkOutput("mid-sync rst MASK", rdVal, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
